// File: rtl/n64_pkg.sv
// N64 joybus transmitter shared types.
// FSM state encoding and default bit-cell timing.
package n64_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIT,
    S_STOP,
    S_GAP
  } state_t;

  localparam int N64_T_LOW  = 100;
  localparam int N64_T_DATA = 300;
  localparam int N64_T_BIT  = 400;

endpackage

// File: rtl/n64_bit_cell.sv
// One joybus bit cell: low pulse, data phase, high tail.
// Also plays the short console-style stop cell.
module n64_bit_cell
  import n64_pkg::*;
#(
  parameter int T_LOW     = N64_T_LOW,
  parameter int T_DATA    = N64_T_DATA,
  parameter int T_BIT     = N64_T_BIT,
  parameter int T_STOP_HI = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic i_go,
  input  logic i_bit,
  input  logic i_short_stop,
  output logic o_level,
  output logic o_cell_done
);

  localparam int CNTW = $clog2(T_BIT);
  localparam logic [CNTW-1:0] C_LOW  = CNTW'(T_LOW);
  localparam logic [CNTW-1:0] C_DATA = CNTW'(T_DATA);
  localparam logic [CNTW-1:0] C_LAST = CNTW'(T_BIT - 1);
  localparam logic [CNTW-1:0] C_SLAST = CNTW'(T_LOW + T_STOP_HI - 1);

  logic [CNTW-1:0] r_cnt;
  logic            r_active;
  logic            r_bit;
  logic            r_short;
  logic            r_level;

  logic [CNTW-1:0] w_last;
  logic [CNTW-1:0] w_cnt_n;
  logic            w_end;
  logic            w_level_n;

  // Cell end detection and level for the next count.
  always_comb begin
    w_last    = r_short ? C_SLAST : C_LAST;
    w_end     = r_active && (r_cnt == w_last);
    w_cnt_n   = r_cnt + CNTW'(1);
    w_level_n = 1'b1;
    if (w_cnt_n < C_LOW) begin
      w_level_n = 1'b0;
    end else if (!r_short && (w_cnt_n < C_DATA)) begin
      w_level_n = r_bit;
    end
  end

  // Counter and registered line level; go wins so cells abut.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_bit    <= 1'b1;
      r_short  <= 1'b0;
      r_level  <= 1'b1;
    end else if (i_go) begin
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_bit    <= i_bit;
      r_short  <= i_short_stop;
      r_level  <= 1'b0;
    end else if (w_end) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_level  <= 1'b1;
    end else if (r_active) begin
      r_cnt    <= w_cnt_n;
      r_level  <= w_level_n;
    end
  end

  assign o_level     = r_level;
  assign o_cell_done = w_end;

endmodule

// File: rtl/n64_tx_frame.sv
// N64 joybus multi-byte frame transmitter.
// Handshake, frame FSM and shift register around a bit cell.
module n64_tx_frame
  import n64_pkg::*;
#(
  parameter int MAX_BYTES  = 4,
  parameter int T_LOW      = N64_T_LOW,
  parameter int T_DATA     = N64_T_DATA,
  parameter int T_BIT      = N64_T_BIT,
  parameter int STOP_MODE  = 0,
  parameter int T_STOP_HI  = 200,
  parameter int GAP_CYCLES = 100
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [$clog2(MAX_BYTES+1)-1:0]   num_bytes,
  input  logic [8*MAX_BYTES-1:0]           payload,
  output logic                             ready,
  output logic                             data_out,
  output logic                             writing_data,
  output logic                             done,
  output logic                             err
);

  localparam int CW = $clog2(MAX_BYTES + 1);
  localparam int IW = $clog2(8 * MAX_BYTES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int NB = 8 * MAX_BYTES;

  state_t          r_state;
  state_t          w_state_n;
  logic [NB-1:0]   r_sr;
  logic [NB-1:0]   w_sr_n;
  logic [NB-1:0]   w_ord;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   w_idx_n;
  logic [IW-1:0]   r_total;
  logic [IW-1:0]   w_total_n;
  logic [GW-1:0]   r_gap;
  logic [GW-1:0]   w_gap_n;
  logic            r_ready;
  logic            w_ready_n;
  logic            r_wr;
  logic            w_wr_n;
  logic            r_done;
  logic            w_done_n;
  logic            r_err;
  logic            w_err_n;
  logic            w_valid;
  logic            w_go;
  logic            w_bit;
  logic            w_short;
  logic            w_level;
  logic            w_cell_done;

  n64_bit_cell #(
    .T_LOW     (T_LOW),
    .T_DATA    (T_DATA),
    .T_BIT     (T_BIT),
    .T_STOP_HI (T_STOP_HI)
  ) u_cell (
    .clk          (clk),
    .rst          (rst),
    .i_go         (w_go),
    .i_bit        (w_bit),
    .i_short_stop (w_short),
    .o_level      (w_level),
    .o_cell_done  (w_cell_done)
  );

  // Byte 0 goes to the top so the frame shifts out MSB-first.
  always_comb begin
    w_ord = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      w_ord[8*(MAX_BYTES-1-b) +: 8] = payload[8*b +: 8];
    end
    w_valid = (num_bytes != '0) && (num_bytes <= CW'(MAX_BYTES));
  end

  // Next-state and next-output logic for the frame FSM.
  always_comb begin
    w_state_n = r_state;
    w_sr_n    = r_sr;
    w_idx_n   = r_idx;
    w_total_n = r_total;
    w_gap_n   = r_gap;
    w_ready_n = r_ready;
    w_wr_n    = r_wr;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    w_go      = 1'b0;
    w_bit     = 1'b1;
    w_short   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_ready_n = 1'b1;
        w_wr_n    = 1'b0;
        if (start) begin
          if (w_valid) begin
            w_go      = 1'b1;
            w_bit     = payload[7];
            w_sr_n    = w_ord << 1;
            w_idx_n   = IW'(1);
            w_total_n = IW'({num_bytes, 3'b000});
            w_state_n = S_BIT;
            w_ready_n = 1'b0;
            w_wr_n    = 1'b1;
          end else begin
            w_err_n = 1'b1;
          end
        end
      end
      S_BIT: begin
        if (w_cell_done) begin
          w_go = 1'b1;
          if (r_idx == r_total) begin
            w_short   = (STOP_MODE != 0);
            w_state_n = S_STOP;
          end else begin
            w_bit   = r_sr[NB-1];
            w_sr_n  = r_sr << 1;
            w_idx_n = r_idx + IW'(1);
          end
        end
      end
      S_STOP: begin
        if (w_cell_done) begin
          w_state_n = S_GAP;
          w_gap_n   = '0;
        end
      end
      S_GAP: begin
        if (r_gap == GW'(GAP_CYCLES - 1)) begin
          w_state_n = S_IDLE;
          w_ready_n = 1'b1;
          w_wr_n    = 1'b0;
          w_done_n  = 1'b1;
        end else begin
          w_gap_n = r_gap + GW'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_idx   <= '0;
      r_total <= '0;
      r_gap   <= '0;
      r_ready <= 1'b1;
      r_wr    <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sr    <= w_sr_n;
      r_idx   <= w_idx_n;
      r_total <= w_total_n;
      r_gap   <= w_gap_n;
      r_ready <= w_ready_n;
      r_wr    <= w_wr_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
    end
  end

  assign ready        = r_ready;
  assign data_out     = w_level;
  assign writing_data = r_wr;
  assign done         = r_done;
  assign err          = r_err;

endmodule

// File: tb/tb_n64_tx_frame.sv
// Bench for n64_tx_frame: two instances (stop styles 0 and 1)
// share stimulus; a waveform-queue model checks every cycle.
module tb_n64_tx_frame;

  localparam int TL = 100;
  localparam int TD = 300;
  localparam int TB = 400;
  localparam int TS = 200;
  localparam int GP = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  num_bytes;
  logic [31:0] payload;
  logic [1:0]  ready;
  logic [1:0]  data_out;
  logic [1:0]  wr;
  logic [1:0]  done;
  logic [1:0]  err;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int n;

  bit q[2][$];
  bit exp_done[2];
  bit exp_err[2];
  bit m_busy;

  always #5 clk = ~clk;

  n64_tx_frame #(
    .MAX_BYTES(4), .T_LOW(TL), .T_DATA(TD), .T_BIT(TB),
    .STOP_MODE(0), .T_STOP_HI(TS), .GAP_CYCLES(GP)
  ) u_d0 (
    .clk(clk), .rst(rst), .start(start),
    .num_bytes(num_bytes), .payload(payload),
    .ready(ready[0]), .data_out(data_out[0]),
    .writing_data(wr[0]), .done(done[0]), .err(err[0])
  );

  n64_tx_frame #(
    .MAX_BYTES(4), .T_LOW(TL), .T_DATA(TD), .T_BIT(TB),
    .STOP_MODE(1), .T_STOP_HI(TS), .GAP_CYCLES(GP)
  ) u_d1 (
    .clk(clk), .rst(rst), .start(start),
    .num_bytes(num_bytes), .payload(payload),
    .ready(ready[1]), .data_out(data_out[1]),
    .writing_data(wr[1]), .done(done[1]), .err(err[1])
  );

  // Whole line waveform of one frame, one entry per cycle.
  function automatic void push_frame(int k, int nb, logic [31:0] pay);
    bit b;
    for (int i = 0; i < nb; i++) begin
      for (int j = 7; j >= 0; j--) begin
        b = pay[8*i+j];
        for (int c = 0; c < TB; c++) begin
          q[k].push_back(c < TL ? 1'b0 : (c < TD ? b : 1'b1));
        end
      end
    end
    if (k == 0) begin
      for (int c = 0; c < TB; c++) q[k].push_back(c >= TL);
    end else begin
      for (int c = 0; c < TL + TS; c++) q[k].push_back(c >= TL);
    end
    for (int c = 0; c < GP; c++) q[k].push_back(1'b1);
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        q[k].delete();
        exp_done[k] = 1'b0;
        exp_err[k]  = 1'b0;
      end else begin
        m_busy = (q[k].size() != 0);
        if (m_busy) void'(q[k].pop_front());
        exp_done[k] = m_busy && (q[k].size() == 0);
        exp_err[k]  = 1'b0;
        if (!m_busy && start) begin
          if (num_bytes >= 1 && num_bytes <= 4)
            push_frame(k, int'(num_bytes), payload);
          else
            exp_err[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] act;
    logic [4:0] exp;
    if (cyc > 0) begin
      for (int k = 0; k < 2; k++) begin
        act = {ready[k], data_out[k], wr[k], done[k], err[k]};
        if (q[k].size() != 0)
          exp = {1'b0, q[k][0], 1'b1, 2'b00};
        else
          exp = {2'b11, 1'b0, exp_done[k], exp_err[k]};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL model d%0d cyc %0d {rdy,dat,wr,done,err} got %b want %b",
                   k, cyc, act, exp);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic at(int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic send(int nb, logic [31:0] pay, output int acc);
    start     = 1'b1;
    num_bytes = 3'(nb);
    payload   = pay;
    acc       = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((ready !== 2'b11) && (t < 20000)) begin
      @(negedge clk);
      t++;
    end
    chk("idle_ready", 32'(ready), 32'h3);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    num_bytes = '0;
    payload   = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'h3);
    chk("rst_data",  32'(data_out), 32'h3);
    chk("rst_wr",    32'(wr), 32'h0);
    chk("rst_done",  32'(done), 32'h0);
    chk("rst_err",   32'(err), 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // one byte 0x00, payload churn and busy start pulse
    send(1, 32'h0, n);
    at(n + 1);    chk("t1_first_low", 32'(data_out), 32'h0);
    at(n + 10);   payload = 32'hFFFF_FFFF;
    at(n + 50);   start = 1'b1;
    @(negedge clk); start = 1'b0;
    at(n + 300);  chk("t1_c299", 32'(data_out), 32'h0);
    at(n + 301);  chk("t1_c300", 32'(data_out), 32'h3);
    at(n + 3300); chk("t1_stop_lo", 32'(data_out), 32'h0);
    at(n + 3301); chk("t1_stop_hi", 32'(data_out), 32'h3);
    at(n + 3601); chk("t1_d1_done", 32'(done[1]), 32'h1);
    at(n + 3700); chk("t1_d0_wr_last", 32'({wr[0], done[0]}), 32'h2);
    at(n + 3701); chk("t1_d0_done", 32'({done[0], ready[0]}), 32'h3);
    at(n + 3702); chk("t1_d0_done_off", 32'(done[0]), 32'h0);
    wait_idle();

    // two bytes 0x01, 0x80
    send(2, 32'h0000_8001, n);
    at(n + 2501); chk("t2_cell6", 32'(data_out), 32'h0);
    at(n + 2901); chk("t2_cell7", 32'(data_out), 32'h3);
    at(n + 3301); chk("t2_cell8", 32'(data_out), 32'h3);
    at(n + 3701); chk("t2_cell9", 32'(data_out), 32'h0);
    wait_idle();

    // invalid lengths
    send(0, 32'h12, n);
    at(n + 1); chk("t3_err0", 32'({err, data_out, ready}), 32'h3F);
    at(n + 2); chk("t3_err0_off", 32'(err), 32'h0);
    send(5, 32'h12, n);
    at(n + 1); chk("t3_err5", 32'({err, data_out, ready}), 32'h3F);
    at(n + 2); chk("t3_err5_off", 32'(err), 32'h0);
    repeat (3) @(negedge clk);

    // 0xFF, console stop on d1
    send(1, 32'hFF, n);
    at(n + 101);  chk("t4_bit1", 32'(data_out), 32'h3);
    at(n + 3300); chk("t4_stop_lo", 32'(data_out), 32'h0);
    at(n + 3301); chk("t4_stop_hi", 32'(data_out), 32'h3);
    at(n + 3600); chk("t4_d1_gap_end", 32'({wr[1], done[1]}), 32'h2);
    at(n + 3601); chk("t4_d1_done", 32'(done[1]), 32'h1);
    wait_idle();

    // reset during bit 5
    send(1, 32'hA5, n);
    at(n + 2051); chk("t5_bit5_low", 32'(data_out), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_abort", 32'({data_out, ready, done, wr}), 32'hF0);
    rst = 1'b0;
    @(negedge clk);
    send(1, 32'h3C, n);
    at(n + 3601); chk("t5_d1_done", 32'(done[1]), 32'h1);
    at(n + 3701); chk("t5_d0_done", 32'(done[0]), 32'h1);
    wait_idle();

    // start held: back-to-back frames
    start     = 1'b1;
    num_bytes = 3'd1;
    payload   = 32'h5A;
    n         = cyc;
    at(n + 3601); chk("t6_d1_done", 32'(done[1]), 32'h1);
    at(n + 3602); chk("t6_d1_relow", 32'(data_out[1]), 32'h0);
    at(n + 3701); chk("t6_d0_done", 32'({done[0], ready[0]}), 32'h3);
    at(n + 3702); chk("t6_d0_relow", 32'({data_out[0], ready[0]}), 32'h0);
    at(n + 7402); chk("t6_d0_done2", 32'(done[0]), 32'h1);
    at(n + 7500); start = 1'b0;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
